// File: rtl/ft232h_sync_writer.sv
// Drains DATA_WIDTH-bit words from a FIFO and writes them byte-wise to an FT232H (FT245 sync FIFO mode).
// Optional send-immediate flush on idle: define FT232H_SEND_IMMEDIATE_EN.
module ft232h_sync_writer #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter bit          MSB_FIRST     = 1'b1,
    parameter int unsigned FLUSH_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  ft_txe_n,
    output logic                  ft_wr_n,
    output logic [7:0]            ft_data,
    output logic                  ft_oe_n,
    output logic                  ft_siwu_n,
    output logic                  busy,
    output logic [15:0]           words_sent
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    if (DATA_WIDTH < 8 || DATA_WIDTH > 32 || (DATA_WIDTH % 8) != 0 || FLUSH_TIMEOUT < 2) begin : g_param_check
        $error("ft232h_sync_writer: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_fifo_rd;
    logic                  w_accept;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_wr_n;
    logic [7:0]            r_data;
    logic                  r_busy;
    logic [15:0]           r_words;

    assign w_accept    = (r_state == SEND) && !r_wr_n && !ft_txe_n;
    assign w_last      = (r_idx == IDX_W'(BYTES - 1));
    assign w_shift_nxt = MSB_FIRST ? (r_shift << 8) : (r_shift >> 8);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and pop strobe; the pop is combinational so data lands in time for FETCH
    always_comb begin
        w_state_nxt = r_state;
        w_fifo_rd   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!fifo_empty) begin
                    w_fifo_rd   = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                w_state_nxt = SEND;
            end
            SEND: begin
                if (w_accept && w_last) begin
                    if (!fifo_empty) begin
                        w_fifo_rd   = 1'b1;
                        w_state_nxt = FETCH;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Byte datapath: load in FETCH, advance only on accepted bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_wr_n  <= 1'b1;
            r_data  <= 8'h00;
            r_busy  <= 1'b0;
            r_words <= 16'h0000;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            case (r_state)
                FETCH: begin
                    r_shift <= fifo_data;
                    r_data  <= MSB_FIRST ? fifo_data[DATA_WIDTH-1 -: 8] : fifo_data[7:0];
                    r_wr_n  <= 1'b0;
                    r_idx   <= '0;
                end
                SEND: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_wr_n  <= 1'b1;
                            r_words <= r_words + 16'd1;
                        end else begin
                            r_shift <= w_shift_nxt;
                            r_data  <= MSB_FIRST ? w_shift_nxt[DATA_WIDTH-1 -: 8] : w_shift_nxt[7:0];
                            r_idx   <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FT232H_SEND_IMMEDIATE_EN
    localparam int unsigned CNT_W = $clog2(FLUSH_TIMEOUT + 1);

    logic             r_pending;
    logic [CNT_W-1:0] r_idle_cnt;
    logic             r_siwu_n;
    logic             w_idle_wait;

    assign w_idle_wait = (r_state == IDLE) && fifo_empty && r_pending;

    // Idle flush timer; at timeout it holds until TXE# allows the pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= 1'b0;
            r_idle_cnt <= '0;
            r_siwu_n   <= 1'b1;
        end else begin
            r_siwu_n <= 1'b1;
            if (w_accept) begin
                r_pending <= 1'b1;
            end
            if (!w_idle_wait) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt == CNT_W'(FLUSH_TIMEOUT - 1)) begin
                if (!ft_txe_n) begin
                    r_siwu_n   <= 1'b0;
                    r_pending  <= 1'b0;
                    r_idle_cnt <= '0;
                end
            end else begin
                r_idle_cnt <= r_idle_cnt + CNT_W'(1);
            end
        end
    end

    assign ft_siwu_n = r_siwu_n;
`else
    assign ft_siwu_n = 1'b1;
`endif

    assign fifo_rd    = w_fifo_rd & rst_n;
    assign ft_wr_n    = r_wr_n;
    assign ft_data    = r_data;
    assign ft_oe_n    = 1'b1;
    assign busy       = r_busy;
    assign words_sent = r_words;

endmodule

// File: tb/tb_ft232h_sync_writer.sv
// Randomized self-checking bench for ft232h_sync_writer: FIFO model plus byte scoreboard,
// with directed cases for latency, burst spacing, TXE# stall, idle and mid-transfer reset.
module tb_ft232h_sync_writer;

    localparam int unsigned DW  = 16;
    localparam int unsigned NB  = DW / 8;
    localparam bit          MSB = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data = '0;
    logic          ft_txe_n = 1'b0;
    logic          ft_wr_n;
    logic [7:0]    ft_data;
    logic          ft_oe_n;
    logic          ft_siwu_n;
    logic          busy;
    logic [15:0]   words_sent;

    logic [DW-1:0] fifo_q[$];
    logic [7:0]    exp_q[$];
    logic [7:0]    acc_byte[$];
    int            acc_cyc[$];
    int            cyc = 0;
    int            acc_since_rst = 0;
    int            pop_n = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    ft232h_sync_writer #(
        .DATA_WIDTH   (DW),
        .MSB_FIRST    (MSB),
        .FLUSH_TIMEOUT(64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_empty(fifo_empty),
        .fifo_rd   (fifo_rd),
        .fifo_data (fifo_data),
        .ft_txe_n  (ft_txe_n),
        .ft_wr_n   (ft_wr_n),
        .ft_data   (ft_data),
        .ft_oe_n   (ft_oe_n),
        .ft_siwu_n (ft_siwu_n),
        .busy      (busy),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected byte order of one word, straight from the byte-ordering rule
    task automatic push_bytes(input logic [DW-1:0] w);
        for (int k = 0; k < int'(NB); k++) begin
            int sh;
            sh = MSB ? (int'(NB) - 1 - k) * 8 : k * 8;
            exp_q.push_back(8'((w >> sh) & 16'hFF));
        end
    endtask

    task automatic wait_idle(input int lim);
        logic done;
        done = 1'b0;
        for (int n = 0; n < lim && !done; n++) begin
            @(negedge clk);
            done = !busy && fifo_empty && (fifo_q.size() == 0) && (exp_q.size() == 0);
        end
        check("idle_reached", done, 1);
    endtask

    // FIFO model: pop sampled mid-cycle, data presented just after the edge
    initial begin
        logic rd_s;
        forever begin
            @(negedge clk);
            rd_s = fifo_rd;
            if (rd_s) check("rd_while_empty", fifo_empty, 0);
            @(posedge clk);
            #1;
            if (rd_s && rst_n && fifo_q.size() > 0) begin
                fifo_data = fifo_q.pop_front();
                push_bytes(fifo_data);
                pop_n++;
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Byte monitor: an FT232H accepts at an edge where WR# and TXE# are both low
    initial begin
        logic       cand;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            cyc++;
            cand = !ft_wr_n && !ft_txe_n;
            b    = ft_data;
            @(posedge clk);
            if (cand && rst_n) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'h0, b}, 32'hFFFF_FFFF);
                end else begin
                    check("byte", b, exp_q.pop_front());
                end
                acc_byte.push_back(b);
                acc_cyc.push_back(cyc);
                acc_since_rst++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, base, c0, viol, siwu_lows, a0;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_wr_n", ft_wr_n, 1);
        check("rst_data", ft_data, 8'h00);
        check("rst_oe_n", ft_oe_n, 1);
        check("rst_siwu_n", ft_siwu_n, 1);
        check("rst_busy", busy, 0);
        check("rst_words", words_sent, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Single word A55A
        @(posedge clk);
        #2;
        p0 = pop_n;
        fifo_q.push_back(16'hA55A);
        wait_idle(50);
        check("a55a_pops", pop_n - p0, 1);
        check("a55a_byte0", acc_byte[acc_byte.size() - 2], 8'hA5);
        check("a55a_byte1", acc_byte[acc_byte.size() - 1], 8'h5A);
        check("a55a_words", words_sent, 1);
        check("a55a_busy", busy, 0);

        // Empty FIFO for 100 cycles
        viol = 0;
        siwu_lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_rd || !ft_wr_n || busy) viol++;
            if (!ft_siwu_n) siwu_lows++;
        end
        check("idle_quiet", viol, 0);
`ifdef FT232H_SEND_IMMEDIATE_EN
        check("siwu_pulses", siwu_lows, 1);
`else
        check("siwu_pulses", siwu_lows, 0);
`endif

        // Three preloaded words, sustained
        @(posedge clk);
        #2;
        base = acc_cyc.size();
        fifo_q.push_back(16'h0102);
        fifo_q.push_back(16'h0304);
        fifo_q.push_back(16'h0506);
        @(posedge clk);
        #2;
        c0 = cyc + 1;
        wait_idle(60);
        check("burst_count", acc_cyc.size() - base, 6);
        if (acc_cyc.size() - base == 6) begin
            check("burst_latency", acc_cyc[base] - c0, 2);
            check("burst_span", acc_cyc[base + 5] - acc_cyc[base], 7);
            check("burst_gap", acc_cyc[base + 2] - acc_cyc[base + 1], 2);
            for (int k = 0; k < 6; k++) check("burst_byte", acc_byte[base + k], 32'(k + 1));
        end
        check("burst_words", words_sent, 4);

        // TXE# stall while 5A is offered
        @(posedge clk);
        #2;
        ft_txe_n = 1'b1;
        base = acc_byte.size();
        fifo_q.push_back(16'h5AC3);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = !ft_wr_n;
        end
        check("stall_offered", seen, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_data", ft_data, 8'h5A);
            check("stall_wr_n", ft_wr_n, 0);
        end
        @(posedge clk);
        #2 ft_txe_n = 1'b0;
        wait_idle(30);
        check("stall_count", acc_byte.size() - base, 2);
        if (acc_byte.size() - base == 2) begin
            check("stall_b0", acc_byte[base], 8'h5A);
            check("stall_b1", acc_byte[base + 1], 8'hC3);
        end
        check("stall_words", words_sent, 5);

        // Reset in the middle of SEND
        @(posedge clk);
        #2;
        a0 = acc_byte.size();
        fifo_q.push_back(16'hBEEF);
        fifo_q.push_back(16'hC0DE);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (acc_byte.size() == a0 + 1);
        end
        check("rst_mid_first", seen, 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        acc_since_rst = 0;
        #1;
        check("mid_rst_fifo_rd", fifo_rd, 0);
        check("mid_rst_wr_n", ft_wr_n, 1);
        check("mid_rst_data", ft_data, 8'h00);
        check("mid_rst_siwu_n", ft_siwu_n, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_words", words_sent, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_idle(40);
        check("post_rst_words", words_sent, 1);
        check("post_rst_b0", acc_byte[acc_byte.size() - 2], 8'hC0);
        check("post_rst_b1", acc_byte[acc_byte.size() - 1], 8'hDE);

        // Random traffic with random TXE# back-pressure
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #2;
            ft_txe_n = ($urandom_range(0, 99) < 30);
            if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0) fifo_q.push_back(DW'($urandom));
        end
        @(posedge clk);
        #2 ft_txe_n = 1'b0;
        wait_idle(200);
        check("rand_words", words_sent, 32'(16'(acc_since_rst / int'(NB))));
        check("rand_partial", acc_since_rst % int'(NB), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
